// File: rtl/sdram_frame_writer_if.sv
// Bundle of the FIFO read-side and SDRAM write-port signals seen by the
// globe frame writer. The writer uses the master modport. The FIFO and the
// SDRAM controller (or a testbench standing in for them) use the slave modport.
interface sdram_frame_writer_if #(
    parameter int ADDR_WIDTH = 22
);
    // Handshake semantics on this bundle:
    //  - FIFO side: readEnable may rise only while readReq is high.
    //    readData holds the popped word during the cycle after readEnable.
    //  - Burst request: wrReq/wrAddr act as valid/payload and stay stable
    //    until the cycle that wrAck is high. That cycle completes the handshake.
    //  - Burst data: wrData is presented throughout the data phase.
    //    A beat is transferred on every rising edge where wrDataReq is high.
    //    Cycles with wrDataReq low are gaps and hold the current beat.
    logic                  readReq;
    logic                  readEnable;
    logic [15:0]           readData;
    logic                  wrReq;
    logic [ADDR_WIDTH-1:0] wrAddr;
    logic                  wrAck;
    logic                  wrDataReq;
    logic [15:0]           wrData;
    logic                  frameDone;
    logic                  frontBuffer;
    logic                  frameValid;

    modport master (
        input  readReq, readData, wrAck, wrDataReq,
        output readEnable, wrReq, wrAddr, wrData, frameDone, frontBuffer, frameValid
    );

    modport slave (
        output readReq, readData, wrAck, wrDataReq,
        input  readEnable, wrReq, wrAddr, wrData, frameDone, frontBuffer, frameValid
    );
endinterface

// File: rtl/sdram_frame_writer.sv
// Collects RGB565 globe pixels from the video FIFO into a small burst buffer.
// Writes each full buffer to SDRAM as one fixed-length burst, ping-ponging
// between two frame buffers. frontBuffer always names the last complete frame.
module sdram_frame_writer #(
    parameter int                    GLB_WIDTH  = 128,
    parameter int                    GLB_HEIGHT = 128,
    parameter int                    BURST_LEN  = 8,
    parameter int                    ADDR_WIDTH = 22,
    parameter logic [ADDR_WIDTH-1:0] BUF0_BASE  = '0,
    parameter logic [ADDR_WIDTH-1:0] BUF1_BASE  = 'h10000
) (
    input  logic                  SDRAM_CLK,
    input  logic                  nReset,
    sdram_frame_writer_if.master  bus,
    output logic [1:0]            dbg_state
);

    localparam int FRAME_WORDS = GLB_WIDTH * GLB_HEIGHT;
    localparam int IDX_W       = $clog2(BURST_LEN);
    localparam int PIX_W       = $clog2(FRAME_WORDS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_WORDS - BURST_LEN);
    localparam logic [PIX_W-1:0] PIX_STEP = PIX_W'(BURST_LEN);

    typedef enum logic [1:0] {
        FILL_REQ   = 2'd0,
        FILL_CAP   = 2'd1,
        BURST_REQ  = 2'd2,
        BURST_DATA = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  fill_idx;
    logic [IDX_W-1:0]  beat_idx;
    logic [PIX_W-1:0]  pix_idx;
    logic              back_buffer;
    logic              front_buffer;
    logic              frame_done;
    logic              frame_valid;
    logic [15:0]       burst_buf [BURST_LEN];

    logic              read_en;
    logic              wr_req;
    logic              capture;
    logic              beat_take;
    logic              burst_last;
    logic              frame_last;

    // Next-state and strobe decode. The FIFO is read at most every other
    // cycle so readReq has caught up with the pop before the next read.
    always_comb begin
        state_d   = state_q;
        read_en   = 1'b0;
        wr_req    = 1'b0;
        capture   = 1'b0;
        beat_take = 1'b0;
        case (state_q)
            FILL_REQ: begin
                if (bus.readReq) begin
                    read_en = 1'b1;
                    state_d = FILL_CAP;
                end
            end
            FILL_CAP: begin
                capture = 1'b1;
                if (fill_idx == LAST_IDX) begin
                    state_d = BURST_REQ;
                end else begin
                    state_d = FILL_REQ;
                end
            end
            BURST_REQ: begin
                wr_req = 1'b1;
                if (bus.wrAck) begin
                    state_d = BURST_DATA;
                end
            end
            BURST_DATA: begin
                if (bus.wrDataReq) begin
                    beat_take = 1'b1;
                    if (beat_idx == LAST_IDX) begin
                        state_d = FILL_REQ;
                    end
                end
            end
            default: state_d = FILL_REQ;
        endcase
    end

    assign burst_last = beat_take && (beat_idx == LAST_IDX);
    assign frame_last = burst_last && (pix_idx == LAST_PIX);

    // State, indices and frame bookkeeping. Reset abandons any burst in flight.
    always_ff @(posedge SDRAM_CLK or negedge nReset) begin
        if (!nReset) begin
            state_q      <= FILL_REQ;
            fill_idx     <= '0;
            beat_idx     <= '0;
            pix_idx      <= '0;
            back_buffer  <= 1'b0;
            front_buffer <= 1'b1;
            frame_done   <= 1'b0;
            frame_valid  <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_done <= frame_last;
            if (capture) begin
                fill_idx <= (fill_idx == LAST_IDX) ? '0 : fill_idx + 1'b1;
            end
            if (beat_take) begin
                beat_idx <= (beat_idx == LAST_IDX) ? '0 : beat_idx + 1'b1;
            end
            if (burst_last) begin
                pix_idx <= frame_last ? '0 : pix_idx + PIX_STEP;
            end
            if (frame_last) begin
                front_buffer <= back_buffer;
                back_buffer  <= ~back_buffer;
                frame_valid  <= 1'b1;
            end
        end
    end

    // Burst buffer storage. Its contents need no reset because they are
    // always refilled before a burst is requested.
    always_ff @(posedge SDRAM_CLK) begin
        if (capture) begin
            burst_buf[fill_idx] <= bus.readData;
        end
    end

    assign bus.readEnable  = read_en;
    assign bus.wrReq       = wr_req;
    assign bus.wrAddr      = (back_buffer ? BUF1_BASE : BUF0_BASE) + ADDR_WIDTH'(pix_idx);
    assign bus.wrData      = burst_buf[beat_idx];
    assign bus.frameDone   = frame_done;
    assign bus.frontBuffer = front_buffer;
    assign bus.frameValid  = frame_valid;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_sdram_frame_writer.sv
// Bench for sdram_frame_writer with a small 4x4 frame and 4-word bursts.
// The bench models the FIFO and the SDRAM controller. It predicts every
// written word's address from the stream position of that word.
module tb_sdram_frame_writer;

    localparam int              GW = 4;
    localparam int              GH = 4;
    localparam int              BL = 4;
    localparam int              AW = 22;
    localparam int              FW = GW * GH;
    localparam logic [AW-1:0]   B0 = '0;
    localparam logic [AW-1:0]   B1 = 22'h100;

    logic       SDRAM_CLK = 1'b0;
    logic       nReset    = 1'b0;
    logic [1:0] dbg_state;

    sdram_frame_writer_if #(.ADDR_WIDTH(AW)) bus ();

    sdram_frame_writer #(
        .GLB_WIDTH (GW),
        .GLB_HEIGHT(GH),
        .BURST_LEN (BL),
        .ADDR_WIDTH(AW),
        .BUF0_BASE (B0),
        .BUF1_BASE (B1)
    ) dut (
        .SDRAM_CLK(SDRAM_CLK),
        .nReset   (nReset),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    // clock / watchdog
    always #5 SDRAM_CLK = ~SDRAM_CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    typedef struct {
        int n_words;
        int ack_delay;
        int gap_mode;
        bit seq_data;
        int exp_bursts;
        int exp_frames;
        bit exp_front;
        bit exp_valid;
    } vec_t;

    vec_t tbl [5];

    int checks = 0;
    int errors = 0;

    logic [15:0]    fifo_q[$];
    logic [AW+15:0] exp_q[$];
    int             rd_cyc[$];

    int  words_pushed, beats_done, bursts_done, frames_seen, cyc;
    bit  rd_pending, prev_re, feed_en, noise_en, first_seen, gap_phase;
    logic [15:0]   rd_word;
    logic [AW-1:0] cur_addr, first_addr;
    int  ctrl_st, ack_cnt, ack_delay, gap_mode, cur_beat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: word n of the stream since reset belongs to frame n/FW,
    // which goes to buffer (frame % 2). Its burst starts at the frame offset
    // rounded down to a burst boundary.
    function automatic logic [AW-1:0] exp_addr(input int n);
        int frame;
        int off;
        frame = n / FW;
        off   = n % FW;
        return ((frame % 2) != 0 ? B1 : B0) + AW'(off - (off % BL));
    endfunction

    task automatic push_word(input logic [15:0] d);
        exp_q.push_back({exp_addr(words_pushed), d});
        fifo_q.push_back(d);
        words_pushed++;
    endtask

    // driver / monitor: one clock cycle of FIFO model, controller model and checks
    task automatic tick();
        bit go;
        logic [AW+15:0] e;
        @(posedge SDRAM_CLK);
        #1;
        if (rd_pending) begin
            bus.readData = rd_word;
            rd_pending   = 1'b0;
        end
        bus.readReq = feed_en && (fifo_q.size() != 0);
        @(negedge SDRAM_CLK);
        cyc++;
        check("read_gate", bus.readEnable && !bus.readReq, 1'b0);
        check("read_spacing", bus.readEnable && prev_re, 1'b0);
        if (bus.readEnable && bus.readReq && fifo_q.size() != 0) begin
            rd_word    = fifo_q.pop_front();
            rd_pending = 1'b1;
            rd_cyc.push_back(cyc);
        end
        prev_re       = bus.readEnable;
        bus.wrAck     = 1'b0;
        bus.wrDataReq = 1'b0;
        if (!nReset) begin
            ctrl_st = 0;
        end else begin
            case (ctrl_st)
                0: begin
                    if (bus.wrReq) begin
                        cur_addr = bus.wrAddr;
                        cur_beat = 0;
                        ack_cnt  = ack_delay;
                        if (!first_seen) begin
                            first_addr = bus.wrAddr;
                            first_seen = 1'b1;
                        end
                        if (ack_cnt == 0) begin
                            bus.wrAck = 1'b1;
                            bursts_done++;
                            gap_phase = 1'b0;
                            ctrl_st   = 2;
                        end else begin
                            ctrl_st = 1;
                        end
                    end else if (noise_en) begin
                        bus.wrAck     = 1'($urandom_range(0, 1));
                        bus.wrDataReq = 1'($urandom_range(0, 1));
                    end
                end
                1: begin
                    check("wrreq_hold", {bus.wrReq, bus.wrAddr}, {1'b1, cur_addr});
                    ack_cnt--;
                    if (ack_cnt == 0) begin
                        bus.wrAck = 1'b1;
                        bursts_done++;
                        gap_phase = 1'b0;
                        ctrl_st   = 2;
                    end
                end
                default: begin
                    if (gap_mode == 0)      go = 1'b1;
                    else if (gap_mode == 1) go = !gap_phase;
                    else                    go = 1'($urandom_range(0, 1));
                    gap_phase = go;
                    if (go) begin
                        bus.wrDataReq = 1'b1;
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL beat_unexpected: got %0h expected none", bus.wrData);
                        end else begin
                            e = exp_q.pop_front();
                            check("beat", {cur_addr, bus.wrData}, e);
                        end
                        beats_done++;
                        cur_beat++;
                        if (cur_beat == BL) ctrl_st = 0;
                    end
                end
            endcase
        end
        if (bus.frameDone) begin
            frames_seen++;
            check("frame_words", beats_done, frames_seen * FW);
            check("front_buffer", bus.frontBuffer, (frames_seen + 1) % 2);
            check("frame_valid", bus.frameValid, 1'b1);
        end
    endtask

    task automatic wait_drain(input int max);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || ctrl_st != 0 || rd_pending) && n < max) begin
            tick();
            n++;
        end
        check("drain_in_time", n < max, 1'b1);
        repeat (3) tick();
    endtask

    // Reset asserted mid-cycle; outputs must fall without waiting for a clock.
    task automatic async_reset(input string tag);
        #2;
        nReset = 1'b0;
        #1;
        check({tag, "_wrreq"}, bus.wrReq, 1'b0);
        check({tag, "_rden"}, bus.readEnable, 1'b0);
        check({tag, "_front"}, bus.frontBuffer, 1'b1);
        check({tag, "_valid"}, bus.frameValid, 1'b0);
        fifo_q.delete();
        exp_q.delete();
        rd_cyc.delete();
        words_pushed = 0; beats_done = 0; bursts_done = 0; frames_seen = 0;
        rd_pending = 1'b0; first_seen = 1'b0; ctrl_st = 0; prev_re = 1'b0;
        bus.wrAck = 1'b0; bus.wrDataReq = 1'b0;
        repeat (3) tick();
        nReset = 1'b1;
    endtask

    initial begin
        tbl[0] = '{4,  0, 0, 1'b1, 1,  0, 1'b1, 1'b0};
        tbl[1] = '{12, 0, 0, 1'b0, 4,  1, 1'b0, 1'b1};
        tbl[2] = '{16, 5, 1, 1'b0, 8,  2, 1'b1, 1'b1};
        tbl[3] = '{8,  2, 1, 1'b0, 10, 2, 1'b1, 1'b1};
        tbl[4] = '{8,  0, 2, 1'b0, 12, 3, 1'b0, 1'b1};

        bus.readReq = 1'b0; bus.readData = '0; bus.wrAck = 1'b0; bus.wrDataReq = 1'b0;
        words_pushed = 0; beats_done = 0; bursts_done = 0; frames_seen = 0; cyc = 0;
        rd_pending = 1'b0; prev_re = 1'b0; feed_en = 1'b0; noise_en = 1'b0;
        first_seen = 1'b0; gap_phase = 1'b0; ctrl_st = 0; ack_cnt = 0;
        ack_delay = 0; gap_mode = 0; cur_beat = 0; cur_addr = '0; first_addr = '0; rd_word = '0;

        // reset state, readReq held low
        repeat (3) tick();
        check("rst_wraddr", bus.wrAddr, B0);
        check("rst_front", bus.frontBuffer, 1'b1);
        check("rst_valid", bus.frameValid, 1'b0);
        check("rst_done", bus.frameDone, 1'b0);
        nReset = 1'b1;
        repeat (6) tick();
        check("idle_reads", rd_cyc.size(), 0);
        check("idle_wrreq", bus.wrReq, 1'b0);
        check("idle_wraddr", bus.wrAddr, B0);
        check("idle_front", bus.frontBuffer, 1'b1);
        check("idle_valid", bus.frameValid, 1'b0);

        // table-driven streaming rows (cumulative since reset)
        feed_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ack_delay = tbl[i].ack_delay;
            gap_mode  = tbl[i].gap_mode;
            rd_cyc.delete();
            for (int k = 0; k < tbl[i].n_words; k++) begin
                if (tbl[i].seq_data) push_word(16'(k + 1));
                else                 push_word(16'($urandom));
            end
            wait_drain(400);
            check("row_bursts", bursts_done, tbl[i].exp_bursts);
            check("row_frames", frames_seen, tbl[i].exp_frames);
            check("row_front", bus.frontBuffer, tbl[i].exp_front);
            check("row_valid", bus.frameValid, tbl[i].exp_valid);
            if (i == 0) begin
                check("first_addr", first_addr, B0);
                check("first_reads", rd_cyc.size(), 4);
                for (int k = 1; k < rd_cyc.size(); k++)
                    check("read_cadence", rd_cyc[k] - rd_cyc[k-1], 2);
            end
        end

        // FIFO runs dry after 2 words and refills 20 cycles later
        ack_delay = 0; gap_mode = 0;
        rd_cyc.delete();
        push_word(16'h0A01); push_word(16'h0A02);
        for (int n = 0; n < 20 && rd_cyc.size() < 2; n++) tick();
        repeat (20) tick();
        check("gap_reads", rd_cyc.size(), 2);
        check("gap_no_burst", bursts_done, 12);
        push_word(16'h0A03); push_word(16'h0A04);
        wait_drain(200);
        check("gap_bursts", bursts_done, 13);

        // reset while a request is waiting for its ack
        ack_delay = 40;
        push_word(16'h0B01); push_word(16'h0B02); push_word(16'h0B03); push_word(16'h0B04);
        for (int n = 0; n < 60 && ctrl_st != 1; n++) tick();
        check("req_seen", ctrl_st, 1);
        async_reset("rst_req");

        // reset during beat 2 of the second burst
        ack_delay = 0; gap_mode = 1;
        for (int k = 0; k < 8; k++) push_word(16'h0C00 + 16'(k));
        for (int n = 0; n < 200 && !(bursts_done == 2 && cur_beat == 2 && ctrl_st == 2); n++) tick();
        check("second_burst_beat2", cur_beat, 2);
        async_reset("rst_beat");
        for (int k = 0; k < 4; k++) push_word(16'h0D00 + 16'(k));
        wait_drain(200);
        check("restart_addr", first_addr, B0);
        check("restart_front", bus.frontBuffer, 1'b1);
        check("restart_bursts", bursts_done, 1);

        // randomized traffic with stray wrAck/wrDataReq between bursts
        noise_en = 1'b1;
        for (int r = 0; r < 8; r++) begin
            int n;
            ack_delay = $urandom_range(0, 4);
            gap_mode  = $urandom_range(0, 2);
            n = BL * $urandom_range(1, 5);
            for (int k = 0; k < n; k++) begin
                push_word(16'($urandom));
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) tick();
            end
            wait_drain(600);
            check("rnd_bursts", bursts_done, words_pushed / BL);
            check("rnd_frames", frames_seen, words_pushed / FW);
            check("rnd_front", bus.frontBuffer, (words_pushed / FW) == 0 ? 1 : ((words_pushed / FW) + 1) % 2);
            check("rnd_valid", bus.frameValid, (words_pushed / FW) != 0);
        end
        noise_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
